pam4_dfe_receiver: RTL and testbench
====================================

# pam4_dfe_receiver

Receive-end block for the ISI channel model. Consumes the channel's signed sample stream (`signal_out` / `signal_out_valid` of the channel), removes post-cursor ISI with a decision-feedback equalizer, and slices each equalized sample into a PAM4 symbol. A lock state machine reports whether decisions are landing close to ideal levels. The block sits between the channel and the BER checker in the SERDES simulation chain.

## Interface
- `SIGNAL_RESOLUTION`, 8: sample width, signed two's complement.
- `SYMBOL_SEPERATION`, 56: spacing between adjacent ideal PAM4 levels. Ideal levels are ±SEP/2 and ±3·SEP/2, i.e. -84, -28, 28, 84.
- `PULSE_RESPONSE_LENGTH`, 3: channel pulse length. The DFE has NTAP = PULSE_RESPONSE_LENGTH-1 post-cursor taps.
- `LOCK_COUNT`, 16: consecutive in-tolerance samples required to lock.
- `ERR_LIMIT`, 4: consecutive out-of-tolerance samples required to drop lock.
- `LOCK_TOL`, 8: maximum allowed |error| for a sample to count as in-tolerance.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: asynchronous, active-high reset.
- `signal_in` in SIGNAL_RESOLUTION: channel sample, signed.
- `signal_in_valid` in 1: sample qualifier; may assert every cycle.
- `coef_wr` in 1: tap write strobe.
- `coef_addr` in clog2(NTAP) (min 1): tap index; index 0 is the first post-cursor.
- `coef_data` in SIGNAL_RESOLUTION: signed tap value (ISI contributed per unit level).
- `sym_out` out 2: decided symbol. 00 → level -3, 01 → -1, 10 → +1, 11 → +3.
- `sym_valid` out 1: qualifies `sym_out` and `eq_out`.
- `eq_out` out SIGNAL_RESOLUTION: equalized sample, saturated.
- `locked` out 1: lock status.

## Operation
- Keep a history of the last NTAP decisions, each with a valid bit. All valid bits clear on reset.
- ISI estimate: isi = Σ tap[k]·lvl(hist[k]), with lvl ∈ {-3,-1,+1,+3}. Entries whose valid bit is clear contribute 0.
- Multiplication by ±1 or ±3 uses shift-add. Internal width is SIGNAL_RESOLUTION+3+clog2(NTAP), and intermediate sums never wrap.
- eq = signal_in − isi, kept at full width.
- Slicer thresholds work on full-width eq:
  - eq < −SEP → 00
  - −SEP ≤ eq < 0 → 01
  - 0 ≤ eq < SEP → 10
  - eq ≥ SEP → 11
- `eq_out` = eq saturated to [−2^(R−1), 2^(R−1)−1].
- On each valid sample, shift the new decision into hist[0] and set its valid bit. Without a valid sample, the history holds.
- error = eq − ideal(sym). A sample is in-tolerance if |error| ≤ LOCK_TOL.
- Lock FSM:
  - SEARCH: counter counts consecutive in-tolerance valid samples. An out-of-tolerance sample resets it to 0. On reaching LOCK_COUNT → LOCKED, counter cleared.
  - LOCKED: counter counts consecutive out-of-tolerance samples. An in-tolerance sample resets it to 0. On reaching ERR_LIMIT → SEARCH, counter cleared.
  - Invalid cycles neither count nor reset the counter.
- Tap writes update the tap register at the clock edge. A sample arriving in the same cycle uses the old tap value. Taps reset to 0.

## Timing
- Latency is 1 cycle: a sample valid at edge n gives `sym_valid`/`sym_out`/`eq_out` registered at edge n+1.
- Throughput is 1 sample per cycle. The feedback path (history → ISI → slicer → history) is single-cycle combinational, so back-to-back samples are fully equalized.
- `sym_valid` is low in any cycle following an invalid input cycle. `sym_out` and `eq_out` hold their last values while `sym_valid` is low.
- `locked` rises on the edge that registers the LOCK_COUNT-th clean sample, i.e. coincident with that sample's `sym_valid`.
- Reset values: `sym_out`=00, `sym_valid`=0, `eq_out`=0, `locked`=0, FSM=SEARCH, counter=0, taps=0, history invalid.
- Reset mid-stream takes effect immediately (asynchronous). The first sample after release is sliced with zero ISI.

## Structure
- Package `serdes_pkg`:
  - symbol encoding enum
  - `lvl()` function (symbol → signed level)
  - `ideal()` function (symbol, SEP → sample value)
  - lock FSM state enum
- Sub-module `pam4_slicer`: combinational, full-width eq → {sym, error}. It is reused by the future CTLE receiver.
- The top holds the taps, history, ISI adder tree, saturation, and FSM.

## Test plan
- Taps 0, input 84 valid → next cycle `sym_out`=11, `eq_out`=84, `sym_valid`=1. Inputs 27, −1, −57 → 10, 01, 00.
- tap0=10, input 84 then 58 back-to-back → second output `sym_out`=10, `eq_out`=28 (isi=30).
- First sample after reset with tap0=50, input 28 → `sym_out`=10, `eq_out`=28 (history invalid, no subtraction).
- Tap write in the same cycle as a valid sample → that sample uses the old tap, the next sample uses the new one.
- Saturation: tap0=127, previous decision 11, input −128 → `eq_out`=−128, `sym_out`=00.
- Lock: 16 clean samples with invalid gaps interleaved → `locked`=1 on the 16th output. Then 3 samples of value 56, one clean sample, then 4 samples of 56 (error −28) → `locked` drops only at the 4th consecutive 56. Assert `rst` mid-stream → all outputs reset immediately.

Source files
------------

// File: rtl/serdes_pkg.sv
// Shared types and helpers for the SERDES receive chain: PAM4 symbol
// encoding, symbol-to-level mapping and the lock state encoding.
package serdes_pkg;

    typedef enum logic [1:0] {
        SYM_M3 = 2'b00,
        SYM_M1 = 2'b01,
        SYM_P1 = 2'b10,
        SYM_P3 = 2'b11
    } sym_t;

    typedef enum logic [0:0] {
        ST_SEARCH = 1'b0,
        ST_LOCKED = 1'b1
    } lock_state_t;

    // Signed unit level carried by a symbol.
    function automatic logic signed [2:0] lvl(input sym_t s);
        logic signed [2:0] l;
        case (s)
            SYM_M3:  l = -3'sd3;
            SYM_M1:  l = -3'sd1;
            SYM_P1:  l = 3'sd1;
            SYM_P3:  l = 3'sd3;
            default: l = 3'sd0;
        endcase
        return l;
    endfunction

    // Ideal sample value of a symbol for a given level spacing.
    function automatic int ideal(input sym_t s, input int sep);
        return (int'(lvl(s)) * sep) / 2;
    endfunction

endpackage

// File: rtl/pam4_slicer.sv
// Combinational PAM4 slicer: decides a symbol from a full-width equalized
// sample and reports the distance from that symbol's ideal level.
module pam4_slicer
    import serdes_pkg::*;
#(
    parameter int W   = 12,
    parameter int SEP = 56
) (
    input  logic signed [W-1:0] eq_i,
    output sym_t                sym_o,
    output logic signed [W-1:0] err_o
);

    localparam logic signed [W-1:0] SEP_POS = W'(SEP);
    localparam logic signed [W-1:0] SEP_NEG = W'(-SEP);
    localparam logic signed [W-1:0] ZERO    = '0;

    logic signed [W-1:0] ideal_s;

    // Threshold the sample against the three decision boundaries
    always_comb begin
        sym_o = SYM_M3;
        if (eq_i < SEP_NEG) begin
            sym_o = SYM_M3;
        end else if (eq_i < ZERO) begin
            sym_o = SYM_M1;
        end else if (eq_i < SEP_POS) begin
            sym_o = SYM_P1;
        end else begin
            sym_o = SYM_P3;
        end
    end

    // Error relative to the ideal level of the decided symbol
    always_comb begin
        ideal_s = W'(ideal(sym_o, SEP));
        err_o   = eq_i - ideal_s;
    end

endmodule

// File: rtl/pam4_dfe_receiver.sv
// PAM4 receiver with decision-feedback equalization. Past decisions weighted
// by programmable post-cursor taps are subtracted from each incoming sample
// before slicing; a lock FSM tracks how close decisions land to ideal levels.
module pam4_dfe_receiver
    import serdes_pkg::*;
#(
    parameter int SIGNAL_RESOLUTION     = 8,
    parameter int SYMBOL_SEPERATION     = 56,
    parameter int PULSE_RESPONSE_LENGTH = 3,
    parameter int LOCK_COUNT            = 16,
    parameter int ERR_LIMIT             = 4,
    parameter int LOCK_TOL              = 8,
    localparam int NTAP   = PULSE_RESPONSE_LENGTH - 1,
    localparam int ADDR_W = (NTAP > 1) ? $clog2(NTAP) : 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic signed [SIGNAL_RESOLUTION-1:0] signal_in,
    input  logic                                signal_in_valid,
    input  logic                                coef_wr,
    input  logic        [ADDR_W-1:0]            coef_addr,
    input  logic signed [SIGNAL_RESOLUTION-1:0] coef_data,
    output logic        [1:0]                   sym_out,
    output logic                                sym_valid,
    output logic signed [SIGNAL_RESOLUTION-1:0] eq_out,
    output logic                                locked
);

    localparam int R      = SIGNAL_RESOLUTION;
    // Headroom: x3 level needs 2 bits, sign of the subtraction 1 bit,
    // and the tap sum grows by clog2(NTAP) bits.
    localparam int W      = R + 3 + $clog2(NTAP);
    localparam int CNT_MX = (LOCK_COUNT > ERR_LIMIT) ? LOCK_COUNT : ERR_LIMIT;
    localparam int CNT_W  = $clog2(CNT_MX + 1);

    localparam logic signed [W-1:0] SAT_MAX_W = W'((1 << (R - 1)) - 1);
    localparam logic signed [W-1:0] SAT_MIN_W = W'(-(1 << (R - 1)));
    localparam logic signed [R-1:0] SAT_MAX_R = {1'b0, {(R - 1){1'b1}}};
    localparam logic signed [R-1:0] SAT_MIN_R = {1'b1, {(R - 1){1'b0}}};
    localparam logic signed [W-1:0] TOL_POS   = W'(LOCK_TOL);
    localparam logic signed [W-1:0] TOL_NEG   = W'(-LOCK_TOL);
    localparam logic [CNT_W-1:0]    LOCK_CNT  = CNT_W'(LOCK_COUNT);
    localparam logic [CNT_W-1:0]    ERR_CNT   = CNT_W'(ERR_LIMIT);

    // Tap and decision history
    logic signed [R-1:0] tap_q      [NTAP];
    logic signed [R-1:0] tap_d      [NTAP];
    sym_t                hist_q     [NTAP];
    sym_t                hist_d     [NTAP];
    logic [NTAP-1:0]     hist_vld_q;
    logic [NTAP-1:0]     hist_vld_d;

    // Registered outputs
    sym_t                sym_q;
    sym_t                sym_d;
    logic                sym_valid_q;
    logic                sym_valid_d;
    logic signed [R-1:0] eq_out_q;
    logic signed [R-1:0] eq_out_d;
    logic                locked_q;
    logic                locked_d;

    // Lock FSM
    lock_state_t         state_q;
    lock_state_t         state_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    cnt_d;

    // Datapath
    logic signed [W-1:0] isi_s;
    logic signed [W-1:0] eq_s;
    logic signed [R-1:0] eq_sat_s;
    sym_t                sym_s;
    logic signed [W-1:0] err_s;
    logic                in_tol_s;
    logic [CNT_W-1:0]    cnt_inc_s;

    // ISI estimate: each valid past decision scales its tap by +-1 or +-3 via shift-add
    always_comb begin
        logic signed [W-1:0] tap_w;
        logic signed [W-1:0] prod;
        tap_w = '0;
        prod  = '0;
        isi_s = '0;
        for (int k = 0; k < NTAP; k++) begin
            tap_w = W'(tap_q[k]);
            if (hist_vld_q[k]) begin
                case (lvl(hist_q[k]))
                    3'sd3:   prod = tap_w + (tap_w <<< 1);
                    3'sd1:   prod = tap_w;
                    -3'sd1:  prod = -tap_w;
                    -3'sd3:  prod = -(tap_w + (tap_w <<< 1));
                    default: prod = '0;
                endcase
            end else begin
                prod = '0;
            end
            isi_s = isi_s + prod;
        end
    end

    // Equalized sample at full width; slicing uses this, not the saturated copy
    always_comb begin
        eq_s = W'(signal_in) - isi_s;
    end

    pam4_slicer #(
        .W   (W),
        .SEP (SYMBOL_SEPERATION)
    ) u_slicer (
        .eq_i  (eq_s),
        .sym_o (sym_s),
        .err_o (err_s)
    );

    // Clamp the equalized sample into the output range
    always_comb begin
        if (eq_s > SAT_MAX_W) begin
            eq_sat_s = SAT_MAX_R;
        end else if (eq_s < SAT_MIN_W) begin
            eq_sat_s = SAT_MIN_R;
        end else begin
            eq_sat_s = eq_s[R-1:0];
        end
    end

    // Tolerance test on the slicer error
    always_comb begin
        in_tol_s  = (err_s <= TOL_POS) && (err_s >= TOL_NEG);
        cnt_inc_s = cnt_q + 1'b1;
    end

    // Next taps, history and output registers
    always_comb begin
        tap_d       = tap_q;
        hist_d      = hist_q;
        hist_vld_d  = hist_vld_q;
        sym_d       = sym_q;
        eq_out_d    = eq_out_q;
        sym_valid_d = signal_in_valid;
        if (coef_wr && (int'(coef_addr) < NTAP)) begin
            tap_d[coef_addr] = coef_data;
        end else begin
            tap_d = tap_q;
        end
        if (signal_in_valid) begin
            for (int k = NTAP - 1; k > 0; k--) begin
                hist_d[k]     = hist_q[k-1];
                hist_vld_d[k] = hist_vld_q[k-1];
            end
            hist_d[0]     = sym_s;
            hist_vld_d[0] = 1'b1;
            sym_d         = sym_s;
            eq_out_d      = eq_sat_s;
        end else begin
            hist_d     = hist_q;
            hist_vld_d = hist_vld_q;
        end
    end

    // Lock FSM: run-length of clean samples to lock, of dirty samples to unlock
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (signal_in_valid) begin
            case (state_q)
                ST_SEARCH: begin
                    if (!in_tol_s) begin
                        cnt_d = '0;
                    end else if (cnt_inc_s == LOCK_CNT) begin
                        state_d = ST_LOCKED;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc_s;
                    end
                end
                ST_LOCKED: begin
                    if (in_tol_s) begin
                        cnt_d = '0;
                    end else if (cnt_inc_s == ERR_CNT) begin
                        state_d = ST_SEARCH;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc_s;
                    end
                end
                default: begin
                    state_d = ST_SEARCH;
                    cnt_d   = '0;
                end
            endcase
        end else begin
            state_d = state_q;
            cnt_d   = cnt_q;
        end
        locked_d = (state_d == ST_LOCKED);
    end

    // Register taps, history and sample outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NTAP; k++) begin
                tap_q[k]  <= '0;
                hist_q[k] <= SYM_M3;
            end
            hist_vld_q  <= '0;
            sym_q       <= SYM_M3;
            sym_valid_q <= 1'b0;
            eq_out_q    <= '0;
        end else begin
            tap_q       <= tap_d;
            hist_q      <= hist_d;
            hist_vld_q  <= hist_vld_d;
            sym_q       <= sym_d;
            sym_valid_q <= sym_valid_d;
            eq_out_q    <= eq_out_d;
        end
    end

    // Register lock FSM state, counter and lock flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_SEARCH;
            cnt_q    <= '0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            locked_q <= locked_d;
        end
    end

    assign sym_out   = sym_q;
    assign sym_valid = sym_valid_q;
    assign eq_out    = eq_out_q;
    assign locked    = locked_q;

endmodule

// File: tb/tb_pam4_dfe_receiver.sv
// Self-checking bench for pam4_dfe_receiver: directed scenarios plus a
// randomized run, all compared against an arithmetic model of the receiver.
module tb_pam4_dfe_receiver;

    logic              clk;
    logic              rst;
    logic signed [7:0] signal_in;
    logic              signal_in_valid;
    logic              coef_wr;
    logic [0:0]        coef_addr;
    logic signed [7:0] coef_data;
    logic [1:0]        sym_out;
    logic              sym_valid;
    logic signed [7:0] eq_out;
    logic              locked;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int m_tap [2];
    int m_hist[2];
    bit m_hv  [2];
    int m_sym;
    int m_eq;
    bit m_vld;
    bit m_locked;
    int m_good;
    int m_bad;

    pam4_dfe_receiver dut (
        .clk             (clk),
        .rst             (rst),
        .signal_in       (signal_in),
        .signal_in_valid (signal_in_valid),
        .coef_wr         (coef_wr),
        .coef_addr       (coef_addr),
        .coef_data       (coef_data),
        .sym_out         (sym_out),
        .sym_valid       (sym_valid),
        .eq_out          (eq_out),
        .locked          (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_tap[k] = 0; m_hist[k] = 0; m_hv[k] = 1'b0;
        end
        m_sym = 0; m_eq = 0; m_vld = 1'b0; m_locked = 1'b0; m_good = 0; m_bad = 0;
    endtask

    function automatic int model_isi();
        int s;
        s = 0;
        for (int k = 0; k < 2; k++) if (m_hv[k]) s += m_tap[k] * m_hist[k];
        return s;
    endfunction

    // Drive one cycle of stimulus, advance the model, return #1 after the edge
    task automatic drive(input bit v, input int x, input bit wr, input int addr, input int data);
        int eq;
        int l;
        int err;
        bit tol;
        @(negedge clk);
        signal_in_valid = v;
        signal_in       = 8'(x);
        coef_wr         = wr;
        coef_addr       = 1'(addr);
        coef_data       = 8'(data);
        if (v) begin
            eq  = x - model_isi();
            l   = (eq < -56) ? -3 : (eq < 0) ? -1 : (eq < 56) ? 1 : 3;
            err = eq - 28 * l;
            tol = (err >= -8) && (err <= 8);
            m_eq  = (eq > 127) ? 127 : (eq < -128) ? -128 : eq;
            m_sym = (l + 3) / 2;
            m_vld = 1'b1;
            if (!m_locked) begin
                m_good = tol ? m_good + 1 : 0;
                if (m_good == 16) begin m_locked = 1'b1; m_good = 0; m_bad = 0; end
            end else begin
                m_bad = tol ? 0 : m_bad + 1;
                if (m_bad == 4) begin m_locked = 1'b0; m_bad = 0; m_good = 0; end
            end
            m_hist[1] = m_hist[0]; m_hv[1] = m_hv[0];
            m_hist[0] = l;         m_hv[0] = 1'b1;
        end else begin
            m_vld = 1'b0;
        end
        if (wr) m_tap[addr] = data;
        @(posedge clk);
        #1;
        signal_in_valid = 1'b0;
        coef_wr         = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        signal_in_valid = 1'b0;
        coef_wr = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #12;
        checks++; if (sym_out !== 2'b00) begin failures++; $display("FAIL reset_sym got=%0d exp=0", sym_out); end
        checks++; if (sym_valid !== 1'b0) begin failures++; $display("FAIL reset_vld got=%0d exp=0", sym_valid); end
        checks++; if (eq_out !== 8'sd0) begin failures++; $display("FAIL reset_eq got=%0d exp=0", eq_out); end
        checks++; if (locked !== 1'b0) begin failures++; $display("FAIL reset_lock got=%0d exp=0", locked); end
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_slicer();
        int xs[4]   = '{84, 27, -1, -57};
        int syms[4] = '{3, 2, 1, 0};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, xs[i], 1'b0, 0, 0);
            checks++; if (sym_out !== 2'(syms[i])) begin failures++; $display("FAIL slice_sym x=%0d got=%0d exp=%0d", xs[i], sym_out, syms[i]); end
            checks++; if (eq_out !== 8'(xs[i])) begin failures++; $display("FAIL slice_eq x=%0d got=%0d exp=%0d", xs[i], eq_out, xs[i]); end
            checks++; if (sym_valid !== 1'b1) begin failures++; $display("FAIL slice_vld got=%0d exp=1", sym_valid); end
        end
        // Idle cycle: valid drops, data holds
        drive(1'b0, 0, 1'b0, 0, 0);
        checks++; if (sym_valid !== 1'b0) begin failures++; $display("FAIL idle_vld got=%0d exp=0", sym_valid); end
        checks++; if (sym_out !== 2'b00 || eq_out !== -8'sd57) begin failures++; $display("FAIL idle_hold got=%0d/%0d exp=0/-57", sym_out, eq_out); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        drive(1'b0, 0, 1'b1, 0, 10);
        drive(1'b1, 84, 1'b0, 0, 0);
        checks++; if (eq_out !== 8'sd84) begin failures++; $display("FAIL b2b_first_eq got=%0d exp=84", eq_out); end
        drive(1'b1, 58, 1'b0, 0, 0);
        checks++; if (sym_out !== 2'b10) begin failures++; $display("FAIL b2b_sym got=%0d exp=2", sym_out); end
        checks++; if (eq_out !== 8'sd28) begin failures++; $display("FAIL b2b_eq got=%0d exp=28", eq_out); end
    endtask

    task automatic test_first_after_reset();
        do_reset();
        drive(1'b0, 0, 1'b1, 0, 50);
        checks++; if (sym_valid !== 1'b0) begin failures++; $display("FAIL far_idle_vld got=%0d exp=0", sym_valid); end
        drive(1'b1, 28, 1'b0, 0, 0);
        checks++; if (sym_out !== 2'b10) begin failures++; $display("FAIL far_sym got=%0d exp=2", sym_out); end
        checks++; if (eq_out !== 8'sd28) begin failures++; $display("FAIL far_eq got=%0d exp=28", eq_out); end
    endtask

    task automatic test_tap_collision();
        do_reset();
        drive(1'b1, 84, 1'b0, 0, 0);
        drive(1'b1, 84, 1'b1, 0, 20);
        checks++; if (eq_out !== 8'sd84) begin failures++; $display("FAIL coll_old_tap got=%0d exp=84", eq_out); end
        drive(1'b1, 84, 1'b0, 0, 0);
        checks++; if (eq_out !== 8'sd24) begin failures++; $display("FAIL coll_new_tap got=%0d exp=24", eq_out); end
        checks++; if (sym_out !== 2'b10) begin failures++; $display("FAIL coll_new_sym got=%0d exp=2", sym_out); end
        // Second tap reaches back two decisions
        drive(1'b0, 0, 1'b1, 1, -5);
        drive(1'b1, 0, 1'b0, 0, 0);
        checks++; if (eq_out !== 8'(m_eq) || m_eq != -5) begin failures++; $display("FAIL tap1_eq got=%0d exp=%0d", eq_out, m_eq); end
    endtask

    task automatic test_saturation();
        do_reset();
        drive(1'b0, 0, 1'b1, 0, 127);
        drive(1'b1, 84, 1'b0, 0, 0);
        drive(1'b1, -128, 1'b0, 0, 0);
        checks++; if (eq_out !== -8'sd128) begin failures++; $display("FAIL sat_low got=%0d exp=-128", eq_out); end
        checks++; if (sym_out !== 2'b00) begin failures++; $display("FAIL sat_sym got=%0d exp=0", sym_out); end
        // Positive clamp: previous decision -3 with tap 127 adds 381
        drive(1'b1, 100, 1'b0, 0, 0);
        checks++; if (eq_out !== 8'sd127 || sym_out !== 2'b11) begin failures++; $display("FAIL sat_high got=%0d/%0d exp=127/3", eq_out, sym_out); end
    endtask

    task automatic test_lock();
        int l;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            l = 2 * int'($urandom_range(0, 3)) - 3;
            drive(1'b1, 28 * l + int'($urandom_range(0, 16)) - 8, 1'b0, 0, 0);
            checks++; if (locked !== (i == 15) || locked !== m_locked) begin failures++; $display("FAIL lock_rise i=%0d got=%0d exp=%0d", i, locked, i == 15); end
            if ($urandom_range(0, 1) == 1) drive(1'b0, 0, 1'b0, 0, 0);
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 56, 1'b0, 0, 0);
            checks++; if (locked !== 1'b1) begin failures++; $display("FAIL lock_hold i=%0d got=%0d exp=1", i, locked); end
        end
        drive(1'b1, -28, 1'b0, 0, 0);
        checks++; if (locked !== 1'b1) begin failures++; $display("FAIL lock_clean got=%0d exp=1", locked); end
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 56, 1'b0, 0, 0);
            checks++; if (locked !== (i < 3)) begin failures++; $display("FAIL lock_drop i=%0d got=%0d exp=%0d", i, locked, i < 3); end
        end
    endtask

    task automatic test_reset_midstream();
        int l;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            l = 2 * int'($urandom_range(0, 3)) - 3;
            drive(1'b1, 28 * l, 1'b0, 0, 0);
        end
        drive(1'b1, 84, 1'b0, 0, 0);
        checks++; if (locked !== 1'b1) begin failures++; $display("FAIL mid_prelock got=%0d exp=1", locked); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (sym_out !== 2'b00 || sym_valid !== 1'b0 || eq_out !== 8'sd0 || locked !== 1'b0) begin
            failures++; $display("FAIL mid_reset got=%0d/%0d/%0d/%0d exp=0/0/0/0", sym_out, sym_valid, eq_out, locked);
        end
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_random();
        int x;
        int l;
        do_reset();
        drive(1'b0, 0, 1'b1, 0, int'($urandom_range(0, 40)) - 20);
        drive(1'b0, 0, 1'b1, 1, int'($urandom_range(0, 40)) - 20);
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 4) != 0) begin
                l = 2 * int'($urandom_range(0, 3)) - 3;
                x = 28 * l + model_isi() + int'($urandom_range(0, 20)) - 10;
                x = (x > 127) ? 127 : (x < -128) ? -128 : x;
            end else begin
                x = int'($urandom_range(0, 255)) - 128;
            end
            if ($urandom_range(0, 40) == 0)
                drive($urandom_range(0, 3) != 0, x, 1'b1, int'($urandom_range(0, 1)), int'($urandom_range(0, 60)) - 30);
            else
                drive($urandom_range(0, 3) != 0, x, 1'b0, 0, 0);
            checks++; if (sym_valid !== m_vld) begin failures++; $display("FAIL rnd_vld i=%0d got=%0d exp=%0d", i, sym_valid, m_vld); end
            checks++; if (sym_out !== 2'(m_sym)) begin failures++; $display("FAIL rnd_sym i=%0d got=%0d exp=%0d", i, sym_out, m_sym); end
            checks++; if (eq_out !== 8'(m_eq)) begin failures++; $display("FAIL rnd_eq i=%0d got=%0d exp=%0d", i, eq_out, m_eq); end
            checks++; if (locked !== m_locked) begin failures++; $display("FAIL rnd_lock i=%0d got=%0d exp=%0d", i, locked, m_locked); end
        end
    endtask

    initial begin
        rst = 1'b1;
        signal_in = '0;
        signal_in_valid = 1'b0;
        coef_wr = 1'b0;
        coef_addr = '0;
        coef_data = '0;
        model_reset();
        test_reset();
        test_slicer();
        test_back_to_back();
        test_first_after_reset();
        test_tap_collision();
        test_saturation();
        test_lock();
        test_reset_midstream();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
